// File: rtl/seq_and_or_pipe.sv
// seq_and_or_pipe: two-stage pipelined AND-OR / OR-AND reduction with
// valid/ready handshake on both sides and a saturating hit counter.
// Optional feature macro: SEQ_AND_OR_GRP_MASK_EN adds a per-group enable
// input (grp_en); a disabled group contributes the identity of the outer
// reduction.
module seq_and_or_pipe #(
  parameter int unsigned GROUPS = 2,
  parameter int unsigned GW     = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [GROUPS*GW-1:0]   in_data,
  input  logic                   mode,
`ifdef SEQ_AND_OR_GRP_MASK_EN
  input  logic [GROUPS-1:0]      grp_en,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   n,
  output logic [CNT_W-1:0]       hit_cnt,
  input  logic                   cnt_clr
);

  logic              s1_valid_q;
  logic [GROUPS-1:0] s1_red_q, s1_red_d;
  logic              s1_mode_q;
  logic              out_valid_q;
  logic              n_q, n_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;

  logic s2_adv, s1_adv, in_xfer, out_xfer;

  // Handshake: each stage advances when its successor can take its contents.
  always_comb begin
    s2_adv   = ~out_valid_q | out_ready;
    s1_adv   = ~s1_valid_q | s2_adv;
    in_xfer  = in_valid & s1_adv;
    out_xfer = out_valid_q & out_ready;
  end

  // Inner (per-group) reduction: AND in mode 0, OR in mode 1.
  always_comb begin
    s1_red_d = '0;
    for (int unsigned k = 0; k < GROUPS; k++) begin
      s1_red_d[k] = mode ? (|in_data[k*GW +: GW]) : (&in_data[k*GW +: GW]);
`ifdef SEQ_AND_OR_GRP_MASK_EN
      // Identity of the outer reduction equals the mode bit (OR->0, AND->1).
      if (!grp_en[k]) s1_red_d[k] = mode;
`endif
    end
  end

  // Outer reduction: OR in mode 0, AND in mode 1.
  always_comb begin
    n_d = s1_mode_q ? (&s1_red_q) : (|s1_red_q);
  end

  // Saturating hit counter next value; clear has priority over increment.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (cnt_clr) begin
      hit_cnt_d = '0;
    end else if (out_xfer && n_q && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + 1'b1;
    end
  end

  // Stage 1 register: per-group reductions, mode and valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_red_q   <= '0;
      s1_mode_q  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_xfer;
      if (in_xfer) begin
        s1_red_q  <= s1_red_d;
        s1_mode_q <= mode;
      end
    end
  end

  // Stage 2 register: final result held stable while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      n_q         <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) n_q <= n_d;
    end
  end

  // Hit counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hit_cnt_q <= '0;
    else      hit_cnt_q <= hit_cnt_d;
  end

  assign in_ready  = s1_adv;
  assign out_valid = out_valid_q;
  assign n         = n_q;
  assign hit_cnt   = hit_cnt_q;

endmodule
